// File: rtl/vga_timing_gen.sv
// VGA raster timing generator (640x480@60 by default).
// The board clock is divided down to a pixel-rate enable. The horizontal and
// vertical counters advance on that enable, and sync/bright are registered
// from the next-state counter values so that they change together with the
// counters. The only state is the div -> h -> v counter chain.
module vga_timing_gen #(
  parameter int CLK_DIV     = 4,
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_VIS_START = 144,
  parameter int H_VIS_END   = 783,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int V_VIS_START = 35,
  parameter int V_VIS_END   = 514
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_en,
  output logic       pix_clk,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       hSync,
  output logic       vSync,
  output logic       bright,
  output logic       line_tick,
  output logic       frame_tick
);

  localparam int DW = $clog2(CLK_DIV);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_SYNC_C = 10'(H_SYNC);
  localparam logic [9:0] H_VS    = 10'(H_VIS_START);
  localparam logic [9:0] H_VE    = 10'(H_VIS_END);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_SYNC_C = 10'(V_SYNC);
  localparam logic [9:0] V_VS    = 10'(V_VIS_START);
  localparam logic [9:0] V_VE    = 10'(V_VIS_END);

  logic [DW-1:0] div_q, div_d;
  logic [9:0]    hcnt_q, hcnt_d;
  logic [9:0]    vcnt_q, vcnt_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          bright_q, bright_d;
  logic          pixclk_q, pixclk_d;

  logic          div_last;
  logic          h_wrap;
  logic          v_wrap;

  // Next-state for the divider and raster counters, plus decode of the
  // next-state counters so the registered flags line up with hCount/vCount.
  always_comb begin
    div_last = (div_q == DIV_LAST);
    // >= rather than == so an out-of-range value can only ever wrap back.
    h_wrap   = (hcnt_q >= H_LAST);
    v_wrap   = (vcnt_q >= V_LAST);

    div_d  = div_last ? '0 : div_q + DW'(1);
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;

    if (div_last) begin
      if (h_wrap) begin
        hcnt_d = '0;
        vcnt_d = v_wrap ? '0 : vcnt_q + 10'd1;
      end else begin
        hcnt_d = hcnt_q + 10'd1;
      end
    end

    hsync_d  = (hcnt_d >= H_SYNC_C);
    vsync_d  = (vcnt_d >= V_SYNC_C);
    bright_d = (hcnt_d >= H_VS) && (hcnt_d <= H_VE) &&
               (vcnt_d >= V_VS) && (vcnt_d <= V_VE);
    // pix_clk rises mid-pixel, away from the counter update edge.
    pixclk_d = (div_d >= DIV_HALF);
  end

  // State registers with synchronous reset; reset returns to raster origin.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q    <= '0;
      hcnt_q   <= '0;
      vcnt_q   <= '0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      bright_q <= 1'b0;
      pixclk_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      hcnt_q   <= hcnt_d;
      vcnt_q   <= vcnt_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      bright_q <= bright_d;
      pixclk_q <= pixclk_d;
    end
  end

  // Strobes are decoded from registered state; rst masks them so no stray
  // pulse escapes during the reset cycle.
  always_comb begin
    pix_en     = div_last & ~rst;
    line_tick  = pix_en & h_wrap;
    frame_tick = line_tick & v_wrap;
  end

  assign pix_clk = pixclk_q;
  assign hCount  = hcnt_q;
  assign vCount  = vcnt_q;
  assign hSync   = hsync_q;
  assign vSync   = vsync_q;
  assign bright  = bright_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen. Instance A uses the default 640x480 timing;
// instance B uses CLK_DIV=2 and a short 8-line frame so whole frames and the
// vertical window edges fit in a short run. Expected outputs come from a
// closed-form model indexed by clocks since the last reset.
module tb_vga_timing_gen;

  typedef struct packed {
    logic       pe;
    logic       pc;
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       br;
    logic       lt;
    logic       ft;
  } out_t;

  typedef struct {
    string   name;
    int      inst;
    int      seg;
    longint  n;
    out_t    exp;
  } vec_t;

  localparam int NV = 26;

  logic clk = 1'b0;
  logic rst_a, rst_b;

  logic       pe_a, pc_a, hs_a, vs_a, br_a, lt_a, ft_a;
  logic [9:0] h_a, v_a;
  logic       pe_b, pc_b, hs_b, vs_b, br_b, lt_b, ft_b;
  logic [9:0] h_b, v_b;

  int     total = 0;
  int     bad   = 0;
  longint n_a   = 0;
  longint n_b   = 0;
  int     seg_a = 0;
  bit     valid = 0;
  int     ft_cnt_b = 0;
  int     vs_low_b = 0;
  int     lt_cnt_a = 0;
  int     pe_cnt_a = 0;
  out_t   q_a[$];
  out_t   q_b[$];
  vec_t   tv[NV];
  bit     hit[NV];

  always #5 clk = ~clk;

  vga_timing_gen u_a (
    .clk(clk), .rst(rst_a), .pix_en(pe_a), .pix_clk(pc_a),
    .hCount(h_a), .vCount(v_a), .hSync(hs_a), .vSync(vs_a),
    .bright(br_a), .line_tick(lt_a), .frame_tick(ft_a)
  );

  vga_timing_gen #(
    .CLK_DIV(2), .H_TOTAL(800), .H_SYNC(96), .H_VIS_START(144), .H_VIS_END(783),
    .V_TOTAL(8), .V_SYNC(2), .V_VIS_START(3), .V_VIS_END(5)
  ) u_b (
    .clk(clk), .rst(rst_b), .pix_en(pe_b), .pix_clk(pc_b),
    .hCount(h_b), .vCount(v_b), .hSync(hs_b), .vSync(vs_b),
    .bright(br_b), .line_tick(lt_b), .frame_tick(ft_b)
  );

  function automatic out_t model(input longint n, input logic r,
                                 input longint cd, input longint ht, input longint hsy,
                                 input longint hvs, input longint hve, input longint vt,
                                 input longint vsy, input longint vvs, input longint vve);
    out_t   m;
    longint d, p, h, v;
    d = n % cd;
    p = n / cd;
    h = p % ht;
    v = (p / ht) % vt;
    m.pe = !r && (d == cd - 1);
    m.pc = (d >= cd / 2);
    m.h  = 10'(h);
    m.v  = 10'(v);
    m.hs = (h >= hsy);
    m.vs = (v >= vsy);
    m.br = (h >= hvs) && (h <= hve) && (v >= vvs) && (v <= vve);
    m.lt = m.pe && (h == ht - 1);
    m.ft = m.lt && (v == vt - 1);
    return m;
  endfunction

  function automatic out_t mk(input logic pe, input logic pc, input int h, input int v,
                              input logic hs, input logic vs, input logic br,
                              input logic lt, input logic ft);
    out_t m;
    m.pe = pe; m.pc = pc; m.h = 10'(h); m.v = 10'(v);
    m.hs = hs; m.vs = vs; m.br = br; m.lt = lt; m.ft = ft;
    return m;
  endfunction

  task automatic check(input string name, input out_t act, input out_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual pe=%b pc=%b h=%0d v=%0d hs=%b vs=%b br=%b lt=%b ft=%b required pe=%b pc=%b h=%0d v=%0d hs=%b vs=%b br=%b lt=%b ft=%b",
               name, act.pe, act.pc, act.h, act.v, act.hs, act.vs, act.br, act.lt, act.ft,
               exp.pe, exp.pc, exp.h, exp.v, exp.hs, exp.vs, exp.br, exp.lt, exp.ft);
    end
  endtask

  task automatic check_int(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // One clock: drive resets, queue expectations, compare, then take the edge.
  task automatic step(input logic ra, input logic rb);
    out_t ea, eb, aa, ab;
    rst_a = ra;
    rst_b = rb;
    if (valid) begin
      q_a.push_back(model(n_a, ra, 4, 800, 96, 144, 783, 525, 2, 35, 514));
      q_b.push_back(model(n_b, rb, 2, 800, 96, 144, 783, 8, 2, 3, 5));
    end
    #1;
    if (valid && q_a.size() > 0 && q_b.size() > 0) begin
      ea = q_a.pop_front();
      eb = q_b.pop_front();
      aa = {pe_a, pc_a, h_a, v_a, hs_a, vs_a, br_a, lt_a, ft_a};
      ab = {pe_b, pc_b, h_b, v_b, hs_b, vs_b, br_b, lt_b, ft_b};
      check($sformatf("sb_a n=%0d seg=%0d", n_a, seg_a), aa, ea);
      check($sformatf("sb_b n=%0d", n_b), ab, eb);
      for (int i = 0; i < NV; i++) begin
        if (tv[i].inst == 0 && tv[i].seg == seg_a && tv[i].n == n_a && !hit[i]) begin
          hit[i] = 1'b1;
          check(tv[i].name, aa, tv[i].exp);
        end
        if (tv[i].inst == 1 && !rb && tv[i].n == n_b && !hit[i]) begin
          hit[i] = 1'b1;
          check(tv[i].name, ab, tv[i].exp);
        end
      end
      if (!rb && ab.ft) ft_cnt_b++;
      if (!rb && n_b < 12800 && !ab.vs) vs_low_b++;
      if (!ra && seg_a == 0 && aa.lt) lt_cnt_a++;
      if (!ra && seg_a == 0 && aa.pe) pe_cnt_a++;
    end
    @(posedge clk);
    n_a = ra ? 0 : n_a + 1;
    n_b = rb ? 0 : n_b + 1;
    valid = 1'b1;
    #1;
  endtask

  initial begin
    int  steps;
    logic ra;
    //            name          inst seg n       pe pc  h    v  hs vs br lt ft
    tv[0]  = '{"a_first_pe",   0, 0, 3,     mk(1, 1,   0,  0, 0, 0, 0, 0, 0)};
    tv[1]  = '{"a_h1",         0, 0, 4,     mk(0, 0,   1,  0, 0, 0, 0, 0, 0)};
    tv[2]  = '{"a_h2",         0, 0, 8,     mk(0, 0,   2,  0, 0, 0, 0, 0, 0)};
    tv[3]  = '{"a_hsync_95",   0, 0, 380,   mk(0, 0,  95,  0, 0, 0, 0, 0, 0)};
    tv[4]  = '{"a_hsync_96",   0, 0, 384,   mk(0, 0,  96,  0, 1, 0, 0, 0, 0)};
    tv[5]  = '{"a_line_tick",  0, 0, 3199,  mk(1, 1, 799,  0, 1, 0, 0, 1, 0)};
    tv[6]  = '{"a_line_wrap",  0, 0, 3200,  mk(0, 0,   0,  1, 0, 0, 0, 0, 0)};
    tv[7]  = '{"a_144_1_dark", 0, 0, 3776,  mk(0, 0, 144,  1, 1, 0, 0, 0, 0)};
    tv[8]  = '{"a_vsync_2",    0, 0, 6400,  mk(0, 0,   0,  2, 0, 1, 0, 0, 0)};
    tv[9]  = '{"a_pre_rst",    0, 0, 8402,  mk(0, 1, 500,  2, 1, 1, 0, 0, 0)};
    tv[10] = '{"a_rst_first",  0, 1, 3,     mk(1, 1,   0,  0, 0, 0, 0, 0, 0)};
    tv[11] = '{"a_rst_h1",     0, 1, 4,     mk(0, 0,   1,  0, 0, 0, 0, 0, 0)};
    tv[12] = '{"a_rst_gate",   0, 1, 3199,  mk(0, 1, 799,  0, 1, 0, 0, 0, 0)};
    tv[13] = '{"a_rst_origin", 0, 2, 0,     mk(0, 0,   0,  0, 0, 0, 0, 0, 0)};
    tv[14] = '{"b_first_pe",   1, 0, 1,     mk(1, 1,   0,  0, 0, 0, 0, 0, 0)};
    tv[15] = '{"b_h1",         1, 0, 2,     mk(0, 0,   1,  0, 0, 0, 0, 0, 0)};
    tv[16] = '{"b_line_tick",  1, 0, 1599,  mk(1, 1, 799,  0, 1, 0, 0, 1, 0)};
    tv[17] = '{"b_line_wrap",  1, 0, 1600,  mk(0, 0,   0,  1, 0, 0, 0, 0, 0)};
    tv[18] = '{"b_144_2_dark", 1, 0, 3488,  mk(0, 0, 144,  2, 1, 1, 0, 0, 0)};
    tv[19] = '{"b_143_3_dark", 1, 0, 5086,  mk(0, 0, 143,  3, 1, 1, 0, 0, 0)};
    tv[20] = '{"b_144_3_lit",  1, 0, 5088,  mk(0, 0, 144,  3, 1, 1, 1, 0, 0)};
    tv[21] = '{"b_783_5_lit",  1, 0, 9566,  mk(0, 0, 783,  5, 1, 1, 1, 0, 0)};
    tv[22] = '{"b_784_5_dark", 1, 0, 9568,  mk(0, 0, 784,  5, 1, 1, 0, 0, 0)};
    tv[23] = '{"b_144_6_dark", 1, 0, 9888,  mk(0, 0, 144,  6, 1, 1, 0, 0, 0)};
    tv[24] = '{"b_frame_tick", 1, 0, 12799, mk(1, 1, 799,  7, 1, 1, 0, 1, 1)};
    tv[25] = '{"b_frame_wrap", 1, 0, 12800, mk(0, 0,   0,  0, 0, 0, 0, 0, 0)};
    for (int i = 0; i < NV; i++) hit[i] = 1'b0;

    rst_a = 1'b1;
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) step(1'b1, 1'b1);

    // A is reset mid-divide at (500,2), then again on its line_tick cycle.
    steps = 0;
    while (n_b < 25601 && bad < 30 && steps < 40000) begin
      ra = ((seg_a == 0 && n_a == 8402) || (seg_a == 1 && n_a == 3199)) ? 1'b1 : 1'b0;
      step(ra, 1'b0);
      if (ra) seg_a++;
      steps++;
    end
    check_int("run_bound", (steps < 40000) ? 1 : 0, 1);

    for (int i = 0; i < NV; i++)
      check_int({"reached_", tv[i].name}, hit[i] ? 1 : 0, 1);
    check_int("b_frame_ticks_2frames", ft_cnt_b, 2);
    check_int("b_vsync_low_clks", vs_low_b, 3200);
    check_int("a_line_ticks_seg0", lt_cnt_a, 2);
    check_int("a_pix_en_seg0", pe_cnt_a, 2100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Generates VGA 640x480@60 raster timing for the display path. It produces the hCount/vCount raster position, the bright (active video) flag and the active-low hSync/vSync. These feed the pixel-consuming controllers, which turn raster position into rgb and use hCount==0 as their once-per-line update point. The block runs from the 100 MHz board clock and derives the pixel rate internally through a clock-enable divider.

Parameters:
CLK_DIV, 4, board clocks per pixel; must be at least 2.
H_TOTAL, 800, pixels per line, counted 0..H_TOTAL-1.
H_SYNC, 96, hSync low for hCount 0..H_SYNC-1.
H_VIS_START, 144, first visible hCount.
H_VIS_END, 783, last visible hCount (inclusive).
V_TOTAL, 525, lines per frame, counted 0..V_TOTAL-1.
V_SYNC, 2, vSync low for vCount 0..V_SYNC-1.
V_VIS_START, 35, first visible vCount.
V_VIS_END, 514, last visible vCount (inclusive).

Ports:
clk  in  1  100 MHz board clock.
rst  in  1  synchronous, active-high reset.
pix_en  out  1  one-clk pulse each pixel period; high while div_cnt==CLK_DIV-1.
pix_clk  out  1  divided square wave; low for the first CLK_DIV/2 div_cnt states, high otherwise. Legacy consumers clock on it.
hCount  out  10  horizontal raster position.
vCount  out  10  vertical raster position.
hSync  out  1  horizontal sync, active low.
vSync  out  1  vertical sync, active low.
bright  out  1  high in the visible window.
line_tick  out  1  one-clk pulse on the pix_en cycle where hCount==H_TOTAL-1.
frame_tick  out  1  one-clk pulse on the pix_en cycle where hCount==H_TOTAL-1 and vCount==V_TOTAL-1.

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk. It dominates every other condition.
  - Values while rst is sampled high: div_cnt=0, hCount=0, vCount=0, hSync=0, vSync=0, bright=0, pix_clk=0. pix_en, line_tick and frame_tick are all 0.
  - Reset mid-frame or mid-divide takes effect at the next edge with no partial-line completion.
- Divider:
  - div_cnt has width $clog2(CLK_DIV) and increments every clk.
  - It wraps from CLK_DIV-1 to 0.
  - pix_en is a combinational decode of the div_cnt register.
- Counters (advance only on a clk edge where pix_en=1):
  - hCount increments. At H_TOTAL-1 it wraps to 0.
  - vCount increments only on that same hCount wrap. At V_TOTAL-1 it wraps to 0.
  - hCount and vCount never exceed H_TOTAL-1 and V_TOTAL-1 respectively.
  - Both are held stable for exactly CLK_DIV clk cycles, which makes them stable across a full pix_clk period.
- Decode:
  - hSync, vSync and bright are registered. They are computed from the next-state counter values so they change on the same edge as hCount/vCount: zero skew, no extra latency.
  - hSync = (hCount >= H_SYNC).
  - vSync = (vCount >= V_SYNC).
  - bright = H_VIS_START <= hCount <= H_VIS_END and V_VIS_START <= vCount <= V_VIS_END.
- Ticks:
  - line_tick and frame_tick are combinational on registered state and coincide with pix_en.
  - On the following edge hCount becomes 0 (and vCount wraps, for frame_tick).
  - frame_tick implies line_tick.
- pix_clk:
  - Rising edge occurs mid-pixel, so the counters are stable at every pix_clk rising edge.
- Timing figures:
  - Line length = H_TOTAL*CLK_DIV clk = 3200.
  - Frame length = 1,680,000 clk.
  - First pix_en is the 4th clk cycle after rst deasserts.
- No state machine beyond the div/h/v counter chain. No illegal states are reachable.

Test Plan:
1. Reset release, run 8 clks. Expect pix_en high only in cycles 4 and 8. hCount goes 0 -> 1 after cycle 4 and 1 -> 2 after cycle 8. pix_clk pattern 0,0,1,1 repeating.
2. Run to hCount=95 -> 96. hSync goes 0 -> 1 on the same edge. At hCount=799 with pix_en high, line_tick=1; next edge gives hCount=0, vCount+1, hSync=0.
3. Visible window: bright=0 at (143,35), 1 at (144,35), 1 at (783,514), 0 at (784,514) and at (144,515). bright=0 for all of vCount 0..34.
4. Full frame: exactly one frame_tick per 1,680,000 clks. vSync low for 2 lines = 6400 clks per frame. Counters return to (0,0) after frame_tick.
5. Assert rst for 1 clk at (500,300) with div_cnt=2. Next cycle all outputs take their reset values and no line_tick or frame_tick pulses. Timing restarts identically to scenario 1.
6. Rerun with CLK_DIV=2. pix_en every 2nd clk, line length 1600 clks, all decode boundaries unchanged in count values.
